pmem_arbiter: RTL and testbench

Shares one single-port physical memory between the I-cache and D-cache physical-memory ports of `cpu_cache_toplevel`. It replaces the dual-port memory model with a single-port one. The block accepts level-held 256-bit line read requests from the I-cache, and line read or write requests from the D-cache. It serialises them onto one memory port with a three-state FSM and routes the response back to the requester that owns the grant.

---
 rtl/pmem_arbiter.sv | 136 +++++++++++++
 tb/tb_pmem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Single-port physical-memory arbiter between the I-cache (read-only) and D-cache (read/write) line ports.
// Optional build macro PMEM_ARB_D_PRIORITY_EN: fixed D-side priority instead of round-robin.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read_i,
  input  logic [ADDR_W-1:0] pmem_address_i,
  output logic [LINE_W-1:0] pmem_rdata_i,
  output logic              pmem_resp_i,
  input  logic              pmem_read_d,
  input  logic              pmem_write_d,
  input  logic [ADDR_W-1:0] pmem_address_d,
  input  logic [LINE_W-1:0] pmem_wdata_d,
  output logic [LINE_W-1:0] pmem_rdata_d,
  output logic              pmem_resp_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

  logic i_pend_s;
  logic d_pend_s;
  logic grant_i_s;
  logic grant_d_s;

  assign i_pend_s = pmem_read_i;
  assign d_pend_s = pmem_read_d | pmem_write_d;

`ifdef PMEM_ARB_D_PRIORITY_EN
  assign grant_i_s = i_pend_s & ~d_pend_s;
`else
  assign grant_i_s = i_pend_s & (~d_pend_s | (last_grant_q == GRANT_D));
`endif
  assign grant_d_s = d_pend_s & ~grant_i_s;

  // Next-state, grant capture and strobe hold/release
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_i_s) begin
          state_d       = SERVE_I;
          last_grant_d  = GRANT_I;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = pmem_address_i;
          mem_wdata_d   = {LINE_W{1'b0}};
        end else if (grant_d_s) begin
          // A simultaneous read+write from D is resolved as a write
          state_d       = SERVE_D;
          last_grant_d  = GRANT_D;
          mem_read_d    = ~pmem_write_d;
          mem_write_d   = pmem_write_d;
          mem_address_d = pmem_address_d;
          mem_wdata_d   = pmem_wdata_d;
        end else begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_D;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= {ADDR_W{1'b0}};
      mem_wdata_q   <= {LINE_W{1'b0}};
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // Completion is forwarded combinationally only to the side holding the grant
  assign pmem_resp_i  = (state_q == SERVE_I) & mem_resp;
  assign pmem_resp_d  = (state_q == SERVE_D) & mem_resp;
  assign pmem_rdata_i = mem_rdata;
  assign pmem_rdata_d = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed self-checking bench for pmem_arbiter; inputs change and outputs are sampled around the negedge.
module tb_pmem_arbiter;

`ifdef PMEM_ARB_D_PRIORITY_EN
  localparam bit D_PRIO = 1'b1;
`else
  localparam bit D_PRIO = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         pmem_read_i;
  logic [31:0]  pmem_address_i;
  logic [255:0] pmem_rdata_i;
  logic         pmem_resp_i;
  logic         pmem_read_d;
  logic         pmem_write_d;
  logic [31:0]  pmem_address_d;
  logic [255:0] pmem_wdata_d;
  logic [255:0] pmem_rdata_d;
  logic         pmem_resp_d;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_R1 = {8{32'h1234_5678}};
  localparam logic [255:0] PAT_R2 = {8{32'hCAFE_F00D}};
  localparam logic [255:0] PAT_W2 = {16{16'h3C69}};

  pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .pmem_read_i(pmem_read_i), .pmem_address_i(pmem_address_i),
    .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i),
    .pmem_read_d(pmem_read_d), .pmem_write_d(pmem_write_d),
    .pmem_address_d(pmem_address_d), .pmem_wdata_d(pmem_wdata_d),
    .pmem_rdata_d(pmem_rdata_d), .pmem_resp_d(pmem_resp_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pmem_read_i = 1'b0; pmem_address_i = 32'h0;
    pmem_read_d = 1'b0; pmem_write_d = 1'b0; pmem_address_d = 32'h0; pmem_wdata_d = 256'h0;
    mem_rdata = 256'h0; mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 256'h0);
    chk("rst_resp_i", pmem_resp_i, 1'b0);
    chk("rst_resp_d", pmem_resp_d, 1'b0);
    rst_n = 1'b1;

    // mem_resp in IDLE is ignored
    mem_resp = 1'b1; #1;
    chk("idle_resp_i", pmem_resp_i, 1'b0);
    chk("idle_resp_d", pmem_resp_d, 1'b0);
    @(negedge clk); mem_resp = 1'b0;
    chk("idle_stays", mem_read, 1'b0);

    // I only, memory latency 3
    pmem_read_i = 1'b1; pmem_address_i = 32'h0000_0060;
    @(negedge clk);
    chk("i_mem_read", mem_read, 1'b1);
    chk("i_mem_write", mem_write, 1'b0);
    chk("i_mem_address", mem_address, 32'h60);
    @(negedge clk);
    chk("i_no_early_resp", pmem_resp_i, 1'b0);
    chk("i_hold_read", mem_read, 1'b1);
    @(negedge clk);
    mem_rdata = PAT_R1; mem_resp = 1'b1; #1;
    chk("i_resp_i", pmem_resp_i, 1'b1);
    chk("i_rdata_i", pmem_rdata_i, PAT_R1);
    chk("i_resp_d_low", pmem_resp_d, 1'b0);
    @(negedge clk);
    pmem_read_i = 1'b0; mem_resp = 1'b0;
    chk("i_done_read_low", mem_read, 1'b0);
    chk("i_resp_pulse_end", pmem_resp_i, 1'b0);

    // D writeback, latency 1
    pmem_write_d = 1'b1; pmem_address_d = 32'h0000_0100; pmem_wdata_d = PAT_A5;
    @(negedge clk);
    chk("dw_mem_write", mem_write, 1'b1);
    chk("dw_mem_read", mem_read, 1'b0);
    chk("dw_mem_address", mem_address, 32'h100);
    chk("dw_mem_wdata", mem_wdata, PAT_A5);
    mem_resp = 1'b1; #1;
    chk("dw_resp_d", pmem_resp_d, 1'b1);
    chk("dw_resp_i_low", pmem_resp_i, 1'b0);
    @(negedge clk);
    pmem_write_d = 1'b0; mem_resp = 1'b0;
    chk("dw_done_write_low", mem_write, 1'b0);

    // D read+write together: write wins
    pmem_read_d = 1'b1; pmem_write_d = 1'b1; pmem_address_d = 32'h0000_0140; pmem_wdata_d = PAT_W2;
    @(negedge clk);
    chk("rw_mem_write", mem_write, 1'b1);
    chk("rw_mem_read", mem_read, 1'b0);
    chk("rw_mem_wdata", mem_wdata, PAT_W2);
    mem_resp = 1'b1;
    @(negedge clk);
    pmem_read_d = 1'b0; pmem_write_d = 1'b0; mem_resp = 1'b0;

    // Requester address change during service is ignored
    pmem_read_i = 1'b1; pmem_address_i = 32'h0000_0040;
    @(negedge clk);
    chk("hold_addr_first", mem_address, 32'h40);
    pmem_address_i = 32'h0000_0200;
    @(negedge clk);
    chk("hold_addr_after_change", mem_address, 32'h40);
    mem_resp = 1'b1; #1;
    chk("hold_resp_i", pmem_resp_i, 1'b1);
    @(negedge clk);
    pmem_read_i = 1'b0; mem_resp = 1'b0;

    // Simultaneous requests from reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pmem_read_i = 1'b1; pmem_address_i = 32'h0000_0040;
    pmem_read_d = 1'b1; pmem_address_d = 32'h0000_0080;
    @(negedge clk);
    chk("sim_first_addr", mem_address, D_PRIO ? 32'h80 : 32'h40);
    chk("sim_first_read", mem_read, 1'b1);
    mem_rdata = PAT_R2; mem_resp = 1'b1; #1;
    chk("sim_first_resp_i", pmem_resp_i, !D_PRIO);
    chk("sim_first_resp_d", pmem_resp_d, D_PRIO);
    @(negedge clk);
    mem_resp = 1'b0;
    if (D_PRIO) pmem_read_d = 1'b0;
    else pmem_read_i = 1'b0;
    chk("sim_dead_read", mem_read, 1'b0);
    chk("sim_dead_write", mem_write, 1'b0);
    @(negedge clk);
    chk("sim_second_addr", mem_address, D_PRIO ? 32'h40 : 32'h80);
    chk("sim_second_read", mem_read, 1'b1);
    mem_resp = 1'b1; #1;
    chk("sim_second_resp_i", pmem_resp_i, D_PRIO);
    chk("sim_second_resp_d", pmem_resp_d, !D_PRIO);
    chk("sim_second_rdata_d", pmem_rdata_d, PAT_R2);
    @(negedge clk);
    mem_resp = 1'b0; pmem_read_i = 1'b0; pmem_read_d = 1'b0;

    // Back-to-back D reads: exactly one dead cycle
    pmem_read_d = 1'b1; pmem_address_d = 32'h0000_00C0;
    @(negedge clk);
    chk("b2b_first_addr", mem_address, 32'hC0);
    mem_resp = 1'b1; #1;
    chk("b2b_first_resp", pmem_resp_d, 1'b1);
    @(negedge clk);
    mem_resp = 1'b0; pmem_address_d = 32'h0000_00E0;
    chk("b2b_dead_read", mem_read, 1'b0);
    chk("b2b_dead_write", mem_write, 1'b0);
    @(negedge clk);
    chk("b2b_second_read", mem_read, 1'b1);
    chk("b2b_second_addr", mem_address, 32'hE0);
    mem_resp = 1'b1; #1;
    chk("b2b_second_resp", pmem_resp_d, 1'b1);
    @(negedge clk);
    mem_resp = 1'b0; pmem_read_d = 1'b0;

    // Reset in the middle of a D write
    pmem_write_d = 1'b1; pmem_address_d = 32'h0000_0300; pmem_wdata_d = PAT_W2;
    @(negedge clk);
    chk("rmid_write_on", mem_write, 1'b1);
    pmem_read_i = 1'b1; pmem_address_i = 32'h0000_03C0;
    rst_n = 1'b0; mem_resp = 1'b1; #1;
    chk("rmid_write_drop", mem_write, 1'b0);
    chk("rmid_read_low", mem_read, 1'b0);
    chk("rmid_no_resp_d", pmem_resp_d, 1'b0);
    @(negedge clk);
    mem_resp = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_regrant_addr", mem_address, D_PRIO ? 32'h300 : 32'h3C0);
    chk("rmid_regrant_read", mem_read, !D_PRIO);
    chk("rmid_regrant_write", mem_write, D_PRIO);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0; pmem_read_i = 1'b0; pmem_write_d = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
